// File: rtl/elc_pkg.sv
// elc_pkg: shared floor width, scheduler state encodings and one-hot helpers
package elc_pkg;
    localparam int N_FLOORS   = 8;
    localparam int MAX_FLOORS = 32;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_DISPATCH = 3'd2;
    localparam logic [2:0] ST_DOOR     = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

    function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [4:0] onehot2idx(input logic [MAX_FLOORS-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_FLOORS; i++)
            if (v[i]) idx = 5'(i);
        return idx;
    endfunction
endpackage

// File: rtl/elc_look_picker.sv
// elc_look_picker: LOOK policy target choice from the pending set and car position
module elc_look_picker #(
    parameter int N_FLOORS = 8,
    parameter int IW = 3
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [IW-1:0]       c,
    input  logic                sched_up,
    output logic [IW-1:0]       target,
    output logic                found,
    output logic                flip
);
    logic [IW-1:0] up_idx, dn_idx;
    logic          has_up, has_dn;

    // nearest pending floor above (lowest) and below (highest) the car
    always_comb begin
        has_up = 1'b0;
        up_idx = '0;
        has_dn = 1'b0;
        dn_idx = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--)
            if (pending[i] && IW'(i) > c) begin
                has_up = 1'b1;
                up_idx = IW'(i);
            end
        for (int i = 0; i < N_FLOORS; i++)
            if (pending[i] && IW'(i) < c) begin
                has_dn = 1'b1;
                dn_idx = IW'(i);
            end
    end

    assign found  = has_up | has_dn;
    assign flip   = sched_up ? (!has_up && has_dn) : (!has_dn && has_up);
    assign target = sched_up ? (has_up ? up_idx : dn_idx) : (has_dn ? dn_idx : up_idx);
endmodule

// File: rtl/iiitb_elc_call_scheduler.sv
// iiitb_elc_call_scheduler: latches floor calls and feeds LOOK-ordered targets to the car controller
module iiitb_elc_call_scheduler
    import elc_pkg::*;
#(
    parameter int N_FLOORS         = elc_pkg::N_FLOORS,
    parameter int DOOR_CYCLES      = 4,
    parameter int DISPATCH_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call_btn,
    input  logic [N_FLOORS-1:0] current_floor,
    input  logic                complete,
    input  logic                over_weight,
    output logic [N_FLOORS-1:0] request_floor,
    output logic                req_valid,
    output logic [N_FLOORS-1:0] pending,
    output logic                door_open,
    output logic                sched_up,
    output logic                timeout_alert
);
    localparam int IW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int TW = $clog2(DISPATCH_TIMEOUT + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    logic [2:0]          state;
    logic [TW-1:0]       timer;
    logic [DW-1:0]       dwell;
    logic [IW-1:0]       c, target;
    logic                found, flip, cur_ok, hit_here, arrive;
    logic [N_FLOORS-1:0] clr;

    assign cur_ok   = is_onehot(MAX_FLOORS'(current_floor));
    assign c        = IW'(onehot2idx(MAX_FLOORS'(current_floor)));
    assign hit_here = pending[c];
    assign arrive   = complete && (current_floor == request_floor);
    assign clr      = (state == ST_SELECT && hit_here) ? N_FLOORS'(1) << c :
                      (state == ST_DISPATCH && arrive) ? request_floor : '0;

    elc_look_picker #(.N_FLOORS(N_FLOORS), .IW(IW)) u_picker (
        .pending (pending),
        .c       (c),
        .sched_up(sched_up),
        .target  (target),
        .found   (found),
        .flip    (flip)
    );

    // call latching, trip sequencing, door dwell and trip watchdog
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            pending       <= '0;
            request_floor <= '0;
            req_valid     <= 1'b0;
            door_open     <= 1'b0;
            sched_up      <= 1'b1;
            timeout_alert <= 1'b0;
            timer         <= '0;
            dwell         <= '0;
        end else begin
            pending <= (pending | call_btn) & ~clr;
            case (state)
                ST_IDLE:
                    if (pending != '0 && !over_weight && cur_ok) state <= ST_SELECT;
                ST_SELECT:
                    if (hit_here) begin
                        door_open <= 1'b1;
                        dwell     <= '0;
                        state     <= ST_DOOR;
                    end else if (found) begin
                        request_floor <= N_FLOORS'(1) << target;
                        req_valid     <= 1'b1;
                        timer         <= '0;
                        sched_up      <= flip ? !sched_up : sched_up;
                        state         <= ST_DISPATCH;
                    end else begin
                        state <= ST_IDLE;
                    end
                ST_DISPATCH:
                    if (arrive) begin
                        request_floor <= '0;
                        req_valid     <= 1'b0;
                        door_open     <= 1'b1;
                        dwell         <= '0;
                        state         <= ST_DOOR;
                    end else if (timer == TW'(DISPATCH_TIMEOUT - 1)) begin
                        request_floor <= '0;
                        req_valid     <= 1'b0;
                        timeout_alert <= 1'b1;
                        timer         <= TW'(DISPATCH_TIMEOUT);
                        state         <= ST_FAULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                ST_DOOR:
                    if (!over_weight) begin
                        if (dwell == DW'(DOOR_CYCLES - 1)) begin
                            door_open <= 1'b0;
                            dwell     <= DW'(DOOR_CYCLES);
                            state     <= (pending != '0 && cur_ok) ? ST_SELECT : ST_IDLE;
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                ST_FAULT: begin
                    request_floor <= '0;
                    req_valid     <= 1'b0;
                    door_open     <= 1'b0;
                    timeout_alert <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iiitb_elc_call_scheduler.sv
// tb_iiitb_elc_call_scheduler: directed scenarios checked against a behavioural trip model
module tb_iiitb_elc_call_scheduler;
    localparam int DOOR = 4;
    localparam int TMO  = 64;

    logic       clk, reset, complete, over_weight;
    logic [7:0] call_btn, current_floor, request_floor, pending;
    logic       req_valid, door_open, sched_up, timeout_alert;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_pend;
    int         m_tgt, m_door, m_age;
    logic       m_sel, m_up, m_fault;

    iiitb_elc_call_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .call_btn     (call_btn),
        .current_floor(current_floor),
        .complete     (complete),
        .over_weight  (over_weight),
        .request_floor(request_floor),
        .req_valid    (req_valid),
        .pending      (pending),
        .door_open    (door_open),
        .sched_up     (sched_up),
        .timeout_alert(timeout_alert)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cidx();
        for (int i = 0; i < 8; i++)
            if (current_floor[i]) return i;
        return 0;
    endfunction

    function automatic int look(input logic up);
        if (up) begin
            for (int i = cidx() + 1; i < 8; i++) if (m_pend[i]) return i;
        end else begin
            for (int i = cidx() - 1; i >= 0; i--) if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic int pick();
        return (look(m_up) >= 0) ? look(m_up) : look(!m_up);
    endfunction

    function automatic logic [7:0] m_clr();
        if (m_fault || m_door > 0) return 8'h00;
        if (m_tgt >= 0)
            return (complete && current_floor == (8'(1) << m_tgt)) ? 8'(1) << m_tgt : 8'h00;
        if (m_sel && m_pend[cidx()]) return 8'(1) << cidx();
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_req();
        return (m_tgt >= 0) ? 8'(1) << m_tgt : 8'h00;
    endfunction

    // trip-level model: door countdown, outstanding target, trip age, fault latch
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend <= 8'h00; m_tgt <= -1; m_door <= 0; m_age <= 0;
            m_sel <= 1'b0; m_up <= 1'b1; m_fault <= 1'b0;
        end else begin
            m_pend <= (m_pend | call_btn) & ~m_clr();
            if (m_fault) begin
            end else if (m_door > 0) begin
                if (!over_weight) begin
                    m_door <= m_door - 1;
                    if (m_door == 1) m_sel <= (m_pend != 0) && ($countones(current_floor) == 1);
                end
            end else if (m_tgt >= 0) begin
                if (complete && current_floor == (8'(1) << m_tgt)) begin
                    m_tgt <= -1; m_door <= DOOR;
                end else begin
                    m_age <= m_age + 1;
                    if (m_age + 1 == TMO) begin m_fault <= 1'b1; m_tgt <= -1; end
                end
            end else if (m_sel) begin
                m_sel <= 1'b0;
                if (m_pend[cidx()]) m_door <= DOOR;
                else if (pick() >= 0) begin
                    m_tgt <= pick(); m_age <= 0;
                    m_up  <= (look(m_up) < 0) ? !m_up : m_up;
                end
            end else if (m_pend != 0 && !over_weight && $countones(current_floor) == 1) begin
                m_sel <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("cmp_pending", 32'(pending), 32'(m_pend));
        chk("cmp_request_floor", 32'(request_floor), 32'(exp_req()));
        chk("cmp_req_valid", 32'(req_valid), 32'(m_tgt >= 0));
        chk("cmp_door_open", 32'(door_open), 32'(m_door > 0));
        chk("cmp_sched_up", 32'(sched_up), 32'(m_up));
        chk("cmp_timeout_alert", 32'(timeout_alert), 32'(m_fault));
    endtask

    task automatic press(input logic [7:0] v);
        call_btn = v;
        tick();
        call_btn = 8'h00;
    endtask

    task automatic arrive_at(input logic [7:0] f);
        current_floor = f;
        complete = 1'b1;
        tick();
        complete = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!req_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_req_valid", 32'(req_valid), 32'd1);
    endtask

    task automatic measure_door(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (door_open) n++;
            tick();
        end
    endtask

    int n, m;

    initial begin
        reset = 1'b0; call_btn = 8'h00; current_floor = 8'h01;
        complete = 1'b0; over_weight = 1'b0;
        repeat (2) tick();
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_sched_up", 32'(sched_up), 32'd1);
        reset = 1'b1;
        tick();

        press(8'h04);
        tick(); tick();
        chk("t1_req_valid", 32'(req_valid), 32'd1);
        chk("t1_request", 32'(request_floor), 32'h04);
        #2 reset = 1'b0;
        #1;
        chk("t1_async_req_valid", 32'(req_valid), 32'd0);
        chk("t1_async_request", 32'(request_floor), 32'h00);
        chk("t1_async_pending", 32'(pending), 32'h00);
        chk("t1_async_sched_up", 32'(sched_up), 32'd1);
        chk("t1_async_door", 32'(door_open), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        press(8'h10);
        chk("t2_pending_k", 32'(pending), 32'h10);
        chk("t2_req_valid_k", 32'(req_valid), 32'd0);
        tick();
        chk("t2_req_valid_k1", 32'(req_valid), 32'd0);
        tick();
        chk("t2_req_valid_k2", 32'(req_valid), 32'd1);
        chk("t2_request", 32'(request_floor), 32'h10);
        arrive_at(8'h10);
        chk("t2_pending_clr", 32'(pending), 32'h00);
        chk("t2_req_drop", 32'(req_valid), 32'd0);
        measure_door(n);
        chk("t2_door_cycles", 32'(n), 32'd4);

        current_floor = 8'h08;
        press(8'h82);
        tick(); tick();
        chk("t3_first_target", 32'(request_floor), 32'h80);
        chk("t3_dir_up", 32'(sched_up), 32'd1);
        arrive_at(8'h80);
        measure_door(n);
        chk("t3_door_cycles", 32'(n), 32'd4);
        wait_req(10);
        chk("t3_second_target", 32'(request_floor), 32'h02);
        chk("t3_dir_flipped", 32'(sched_up), 32'd0);
        arrive_at(8'h02);
        measure_door(n);

        current_floor = 8'h08;
        press(8'h08);
        tick(); tick();
        chk("t4_door", 32'(door_open), 32'd1);
        chk("t4_no_req", 32'(req_valid), 32'd0);
        chk("t4_pending", 32'(pending), 32'h00);
        measure_door(n);
        chk("t4_door_cycles", 32'(n), 32'd4);

        press(8'h08);
        tick(); tick();
        over_weight = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (door_open) n++;
            tick();
        end
        over_weight = 1'b0;
        measure_door(m);
        chk("t5_door_cycles_ow", 32'(n + m), 32'd14);
        over_weight = 1'b1;
        current_floor = 8'h01;
        press(8'h20);
        repeat (5) tick();
        chk("t5_ow_no_dispatch", 32'(req_valid), 32'd0);
        chk("t5_ow_pending", 32'(pending), 32'h20);
        over_weight = 1'b0;
        wait_req(10);
        chk("t5_target", 32'(request_floor), 32'h20);
        chk("t5_dir", 32'(sched_up), 32'd1);

        repeat (TMO - 1) tick();
        chk("t6_still_dispatch", 32'(req_valid), 32'd1);
        chk("t6_no_alert_yet", 32'(timeout_alert), 32'd0);
        tick();
        chk("t6_alert", 32'(timeout_alert), 32'd1);
        chk("t6_req_drop", 32'(req_valid), 32'd0);
        chk("t6_request_zero", 32'(request_floor), 32'h00);
        press(8'h04);
        arrive_at(8'h20);
        repeat (5) tick();
        chk("t6_alert_sticky", 32'(timeout_alert), 32'd1);
        chk("t6_pending_latch", 32'(pending), 32'h24);
        chk("t6_door_closed", 32'(door_open), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("t6_reset_alert", 32'(timeout_alert), 32'd0);
        chk("t6_reset_pending", 32'(pending), 32'h00);
        tick();
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
